// File: rtl/rexor_pattern_sequencer.sv
// rexor_pattern_sequencer: applies exhaustive/LFSR patterns to a parity gate and checks its response
module rexor_pattern_sequencer #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 9,
  parameter int SETTLE = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] num_pat,
  output logic [WIDTH-1:0] pattin,
  input  logic             dut_o,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [WIDTH-1:0] first_fail_pat
);
  localparam int WW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(1) << WIDTH;
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
  state_t r_state, w_next;
  logic             r_mode, r_fail, r_done, w_mis, w_wait_end;
  logic [CNT_W-1:0] r_rem, r_mcnt;
  logic [WIDTH-1:0] r_pat, r_ffp, w_adv;
  logic [WW-1:0]    r_wcnt;
  assign w_mis      = dut_o != ^r_pat;
  assign w_adv      = r_mode ? {r_pat[WIDTH-2:0], r_pat[7] ^ r_pat[5] ^ r_pat[4] ^ r_pat[3]} : r_pat + 1'b1;
  assign w_wait_end = r_wcnt == WW'(SETTLE - 1);
  assign pattin         = r_pat;
  assign busy           = r_state == APPLY || r_state == WAIT || r_state == CHECK;
  assign done           = r_done;
  assign fail           = r_fail;
  assign mismatch_cnt   = r_mcnt;
  assign first_fail_pat = r_ffp;
  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // Next-state: a zero-length LFSR run skips straight to DONE; abort overrides everything outside IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ((mode && num_pat == '0) ? DONE : APPLY) : IDLE;
      APPLY:   w_next = SETTLE > 0 ? WAIT : CHECK;
      WAIT:    w_next = w_wait_end ? CHECK : WAIT;
      CHECK:   w_next = r_rem == CNT_W'(1) ? DONE : APPLY;
      default: w_next = IDLE;
    endcase
    if (abort && r_state != IDLE) w_next = IDLE;
  end
  // Datapath: run setup, settle counter, response check and pattern advance; done is registered one cycle after DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_pat  <= '0;
      r_rem  <= '0;
      r_mcnt <= '0;
      r_fail <= 1'b0;
      r_ffp  <= '0;
      r_done <= 1'b0;
      r_wcnt <= '0;
    end else begin
      r_done <= r_state == DONE && !abort;
      r_wcnt <= r_state == WAIT ? r_wcnt + 1'b1 : '0;
      if (r_state == IDLE && start) begin
        r_mode <= mode;
        r_pat  <= mode ? (seed == '0 ? WIDTH'(1) : seed) : '0;
        r_rem  <= mode ? num_pat : FULL;
        r_mcnt <= '0;
        r_fail <= 1'b0;
        r_ffp  <= '0;
      end
      if (r_state == CHECK && !abort) begin
        r_rem <= r_rem - 1'b1;
        if (r_rem != CNT_W'(1)) r_pat <= w_adv;
        if (w_mis) begin
          r_mcnt <= &r_mcnt ? r_mcnt : r_mcnt + 1'b1;
          r_fail <= 1'b1;
          if (r_mcnt == '0) r_ffp <= r_pat;
        end
      end
    end
  end
endmodule

// File: tb/tb_rexor_pattern_sequencer.sv
// tb_rexor_pattern_sequencer: directed checks of the parity pattern sequencer
module tb_rexor_pattern_sequencer;
  logic       clk = 0, rst = 0, start = 0, abort = 0, mode = 0, dut_o;
  logic [7:0] seed = 0, pattin, first_fail_pat;
  logic [8:0] num_pat = 0, mismatch_cnt;
  logic       busy, done, fail;
  logic [1:0] fault = 0;
  int         checks = 0, errors = 0, cyc;
  bit         got, saw_busy;
  logic [7:0] seq[$];

  assign dut_o = fault == 0 ? ^pattin : fault == 1 ? 1'b0 : 1'b1;

  rexor_pattern_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .num_pat(num_pat), .pattin(pattin), .dut_o(dut_o),
    .busy(busy), .done(done), .fail(fail), .mismatch_cnt(mismatch_cnt),
    .first_fail_pat(first_fail_pat)
  );

  always #5 clk = ~clk;

  task automatic run(input logic m, input logic [7:0] sd, input logic [8:0] np);
    @(negedge clk);
    mode = m; seed = sd; num_pat = np; start = 1;
    @(posedge clk);
    cyc = 0; got = 0; saw_busy = 0; seq.delete();
    while (cyc < 2000 && !got) begin
      @(negedge clk);
      start = 0; mode = !m; seed = 8'hA5; num_pat = 9'd3;
      if (busy) begin
        saw_busy = 1;
        if (seq.size() == 0 || seq[$] !== pattin) seq.push_back(pattin);
      end
      if (done) got = 1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL run_timeout: no done after %0d cycles", cyc); end
    @(negedge clk);
    checks++;
    if (done !== 0 || busy !== 0) begin errors++; $display("FAIL done_pulse: done=%b busy=%b required 0 0", done, busy); end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    checks++;
    if ({pattin, busy, done, fail, mismatch_cnt, first_fail_pat} !== '0)
      begin errors++; $display("FAIL reset: pat=%h busy=%b done=%b fail=%b mc=%0d ffp=%h required all 0", pattin, busy, done, fail, mismatch_cnt, first_fail_pat); end
  endtask

  task automatic test_exhaustive;
    int bad = 0;
    fault = 0;
    run(0, 8'h00, 9'd0);
    for (int i = 0; i < seq.size(); i++) if (seq[i] !== i[7:0]) bad++;
    checks++;
    if (cyc !== 769) begin errors++; $display("FAIL exh_latency: %0d required 769", cyc); end
    checks++;
    if (seq.size() !== 256 || bad !== 0) begin errors++; $display("FAIL exh_seq: size=%0d bad=%0d required 256 0", seq.size(), bad); end
    checks++;
    if (mismatch_cnt !== 0 || fail !== 0) begin errors++; $display("FAIL exh_clean: mc=%0d fail=%b required 0 0", mismatch_cnt, fail); end
  endtask

  task automatic test_stuck(input logic [1:0] f, input logic [7:0] exp_ffp);
    fault = f;
    run(0, 8'h00, 9'd0);
    checks++;
    if (mismatch_cnt !== 128 || fail !== 1 || first_fail_pat !== exp_ffp)
      begin errors++; $display("FAIL stuck%0d: mc=%0d fail=%b ffp=%h required 128 1 %h", f - 1, mismatch_cnt, fail, first_fail_pat, exp_ffp); end
    fault = 0;
  endtask

  task automatic test_lfsr(input logic [7:0] sd);
    logic [7:0] lexp [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    int bad = 0;
    fault = 0;
    run(1, sd, 9'd5);
    if (seq.size() == 5) for (int i = 0; i < 5; i++) if (seq[i] !== lexp[i]) bad++;
    checks++;
    if (seq.size() !== 5 || bad !== 0) begin errors++; $display("FAIL lfsr_seq seed=%h: size=%0d bad=%0d required 5 0", sd, seq.size(), bad); end
    checks++;
    if (cyc !== 16 || mismatch_cnt !== 0) begin errors++; $display("FAIL lfsr_run seed=%h: cyc=%0d mc=%0d required 16 0", sd, cyc, mismatch_cnt); end
  endtask

  task automatic test_zero_count;
    fault = 1;
    run(1, 8'h33, 9'd0);
    checks++;
    if (cyc !== 1 || saw_busy !== 0 || mismatch_cnt !== 0)
      begin errors++; $display("FAIL zero_count: cyc=%0d busy_seen=%b mc=%0d required 1 0 0", cyc, saw_busy, mismatch_cnt); end
    fault = 0;
  endtask

  task automatic test_abort;
    int n = 0;
    bit pulsed = 0, saw_done = 0;
    fault = 1;
    @(negedge clk);
    mode = 0; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    while (pattin !== 8'h04 && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (pattin === 8'h02 && !pulsed) begin start = 1; pulsed = 1; end
      else start = 0;
    end
    checks++;
    if (pattin !== 8'h04) begin errors++; $display("FAIL abort_reach: pat=%h required 04", pattin); end
    abort = 1;
    @(posedge clk);
    @(negedge clk);
    abort = 0;
    checks++;
    if (busy !== 0 || mismatch_cnt !== 2 || first_fail_pat !== 8'h01 || fail !== 1)
      begin errors++; $display("FAIL abort_state: busy=%b mc=%0d ffp=%h fail=%b required 0 2 01 1", busy, mismatch_cnt, first_fail_pat, fail); end
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_nodone: done/busy seen=1 required 0"); end
    fault = 0;
  endtask

  task automatic test_rst_midrun;
    int n = 0;
    fault = 2;
    @(negedge clk);
    mode = 0; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    while (pattin !== 8'h40 && n < 400) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (pattin !== 8'h40 || mismatch_cnt === 0) begin errors++; $display("FAIL rst_reach: pat=%h mc=%0d required 40 nonzero", pattin, mismatch_cnt); end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    checks++;
    if ({pattin, busy, done, fail, mismatch_cnt, first_fail_pat} !== '0)
      begin errors++; $display("FAIL rst_midrun: pat=%h busy=%b done=%b fail=%b mc=%0d ffp=%h required all 0", pattin, busy, done, fail, mismatch_cnt, first_fail_pat); end
    fault = 0;
    run(0, 8'h00, 9'd0);
    checks++;
    if (cyc !== 769 || seq.size() !== 256 || seq[0] !== 8'h00 || mismatch_cnt !== 0)
      begin errors++; $display("FAIL rst_rerun: cyc=%0d size=%0d first=%h mc=%0d required 769 256 00 0", cyc, seq.size(), seq[0], mismatch_cnt); end
  endtask

  initial begin
    test_reset;
    test_exhaustive;
    test_stuck(2'd1, 8'h01);
    test_stuck(2'd2, 8'h00);
    test_lfsr(8'h01);
    test_lfsr(8'h00);
    test_zero_count;
    test_abort;
    test_rst_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
